// File: rtl/corescore_rst_conditioner.sv
// Push-button reset conditioner for the board clock generator.
// Synchronizes and debounces a raw button, emits a one-cycle press pulse and
// a registered debounced level, and stretches every accepted press (and every
// system reset) into an active-high reset of at least HOLD_CYCLES cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// HOLD     | o_rst high, hold_cnt counting out the minimum stretch
// WAIT_REL | o_rst high, minimum stretch done, waiting for button release
// IDLE     | o_rst low, waiting for the next accepted press
module corescore_rst_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int HOLD_CYCLES       = 16,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_rst,
    output logic o_press,
    output logic o_btn
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(1);

    // Raw pin level when the button is not pressed.
    localparam logic BTN_RELEASED = BUTTON_ACTIVE_LOW;

    localparam logic [1:0] ST_HOLD     = 2'd0;
    localparam logic [1:0] ST_WAIT_REL = 2'd1;
    localparam logic [1:0] ST_IDLE     = 2'd2;

    logic              sync_q1;
    logic              sync_q2;
    logic              synced_pressed;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic              db_rise;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;

    // Two-flop synchronizer; resets to the released level so a held button is
    // seen as a fresh press once reset lifts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q1 <= BTN_RELEASED;
            sync_q2 <= BTN_RELEASED;
        end else begin
            sync_q1 <= i_btn;
            sync_q2 <= sync_q1;
        end
    end

    assign synced_pressed = sync_q2 ^ BTN_RELEASED;

    // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing sample discards the partial count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (synced_pressed == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_level <= ~db_level;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // o_btn is the previous db_level, so comparing the two finds the edge.
    assign db_rise = db_level & ~o_btn;

    // Registered debounced level and single-cycle press pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_btn   <= 1'b0;
            o_press <= 1'b0;
        end else begin
            o_btn   <= db_level;
            o_press <= db_rise;
        end
    end

    // Next-state logic. A press loads hold_cnt with 1 because its entry edge
    // already drives o_rst high; after system reset the count starts at 0 so
    // the stretch covers HOLD_CYCLES full edges after release.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = db_level ? ST_WAIT_REL : ST_IDLE;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!db_level) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (db_rise) begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = HOLD_FIRST;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // State register; o_rst is decoded from the next state into a flop so the
    // clock generator never sees a combinational glitch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            o_rst    <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            o_rst    <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_corescore_rst_conditioner.sv
// Bench for corescore_rst_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16,
// active-low button. A timing-rule reference model checks every edge.
module tb_corescore_rst_conditioner;

    localparam int D = 4;
    localparam int H = 16;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    logic i_btn   = 1'b1;
    logic o_rst;
    logic o_press;
    logic o_btn;

    int n_checks = 0;
    int n_errors = 0;

    corescore_rst_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .HOLD_CYCLES      (H),
        .BUTTON_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn  (i_btn),
        .o_rst  (o_rst),
        .o_press(o_press),
        .o_btn  (o_btn)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: pressed-history window, debounced level, and the
    // reset stretch expressed as an end-edge number plus a release wait.
    bit pq[$];
    bit m_lvl;
    bit m_obtn;
    int m_edge;
    bit m_hold;
    bit m_wait;
    int m_hold_end;
    bit e_rst;
    bit e_press;
    bit e_btn;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0b required=%0b time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        for (int i = 0; i < D + 2; i++) pq.push_back(1'b0);
        m_lvl      = 1'b0;
        m_obtn     = 1'b0;
        m_edge     = 0;
        m_hold     = 1'b1;
        m_wait     = 1'b0;
        m_hold_end = H + 1;
        e_rst      = 1'b1;
        e_press    = 1'b0;
        e_btn      = 1'b0;
    endtask

    task automatic model_edge(input bit raw);
        bit all_diff;
        m_edge++;
        e_press = m_lvl & ~m_obtn;
        e_btn   = m_lvl;
        if (m_hold) begin
            if (m_edge == m_hold_end) begin
                m_hold = 1'b0;
                m_wait = m_lvl;
            end
        end else if (m_wait) begin
            if (!m_lvl) m_wait = 1'b0;
        end else if (e_press) begin
            m_hold     = 1'b1;
            m_hold_end = m_edge + H;
        end
        e_rst  = m_hold | m_wait;
        m_obtn = m_lvl;
        // Window pq[0..D-1] holds the D synchronized samples seen at this edge.
        pq.push_back(~raw);
        void'(pq.pop_front());
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) if (pq[i] == m_lvl) all_diff = 1'b0;
        if (all_diff) m_lvl = ~m_lvl;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".o_rst"},   o_rst,   e_rst);
        check({tag, ".o_press"}, o_press, e_press);
        check({tag, ".o_btn"},   o_btn,   e_btn);
    endtask

    // Starts and ends at a falling edge.
    task automatic step(input bit b);
        i_btn = b;
        @(posedge i_clk);
        model_edge(b);
        #1;
        check_model("model");
        @(negedge i_clk);
    endtask

    // Asserts reset 2 time units after the falling edge (mid-cycle), holds it
    // for a number of rising edges, releases on a falling edge.
    task automatic do_reset(input int cycles);
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rst_async");
        for (int i = 0; i < cycles; i++) begin
            @(posedge i_clk);
            #1;
            check_model("rst_held");
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    typedef struct {
        string name;
        int    low_len;
        int    press_edge;
        int    rst_fall;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int presses;
        int press_at;
        int fall_at;
        bit rst_all_high;
        bit b;
        int run;

        vecs[0] = '{"pulse1",   1, -1, -1};
        vecs[1] = '{"glitch3",  3, -1, -1};
        vecs[2] = '{"min4",     4,  6, 22};
        vecs[3] = '{"short5",   5,  6, 22};
        vecs[4] = '{"rel16",   16,  6, 22};
        vecs[5] = '{"rel17",   17,  6, 23};
        vecs[6] = '{"long40",  40,  6, 46};

        @(negedge i_clk);

        // Reset stretch: 5 cycles in reset, o_rst high 16 edges after release.
        i_btn = 1'b1;
        do_reset(5);
        for (int e = 0; e < 20; e++) begin
            step(1'b1);
            check("stretch.o_rst", o_rst, (e < H) ? 1'b1 : 1'b0);
            check("stretch.o_press", o_press, 1'b0);
        end

        // Table of single-press scenarios, each from IDLE.
        foreach (vecs[v]) begin
            for (int e = 0; e < 60; e++) begin
                step((e < vecs[v].low_len) ? 1'b0 : 1'b1);
                check({vecs[v].name, ".press"}, o_press,
                      (e == vecs[v].press_edge) ? 1'b1 : 1'b0);
                check({vecs[v].name, ".rst"}, o_rst,
                      (vecs[v].press_edge >= 0 && e >= vecs[v].press_edge
                       && e < vecs[v].rst_fall) ? 1'b1 : 1'b0);
                check({vecs[v].name, ".btn"}, o_btn,
                      (vecs[v].press_edge >= 0 && e >= 6
                       && e < vecs[v].low_len + 6) ? 1'b1 : 1'b0);
            end
        end

        // Bounce: toggle every cycle for 20 cycles, then settle pressed.
        presses  = 0;
        press_at = -1;
        for (int e = 0; e < 50; e++) begin
            step((e < 20) ? ((e % 2) != 0) : 1'b0);
            if (o_press) begin
                presses++;
                press_at = e;
            end
        end
        check_int("bounce.presses", presses, 1);
        check_int("bounce.press_edge", press_at, 26);
        for (int e = 0; e < 40; e++) step(1'b1);

        // Reset while in WAIT_REL with the button held throughout.
        for (int e = 0; e < 30; e++) step(1'b0);
        do_reset(3);
        presses      = 0;
        press_at     = -1;
        rst_all_high = 1'b1;
        for (int e = 0; e < 30; e++) begin
            step(1'b0);
            if (o_press) begin
                presses++;
                press_at = e;
            end
            if (!o_rst) rst_all_high = 1'b0;
        end
        check_int("held_rst.presses", presses, 1);
        check_int("held_rst.press_edge", press_at, 6);
        check("held_rst.rst_continuous", rst_all_high, 1'b1);
        fall_at = -1;
        for (int e = 0; e < 20; e++) begin
            step(1'b1);
            if (!o_rst && fall_at < 0) fall_at = e;
        end
        check_int("held_rst.rst_fall_edge", fall_at, 6);

        // Reset mid-debounce discards the partial count.
        for (int e = 0; e < 3; e++) step(1'b0);
        do_reset(2);
        presses = 0;
        for (int e = 0; e < 30; e++) begin
            step(1'b1);
            if (o_press) presses++;
        end
        check_int("mid_db_rst.presses", presses, 0);

        // Randomized runs with occasional resets, checked by the model.
        b = 1'b1;
        for (int r = 0; r < 400; r++) begin
            b   = ~b;
            run = $urandom_range(1, 7);
            if (r % 10 == 9) run = $urandom_range(18, 30);
            for (int e = 0; e < run; e++) step(b);
            if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/corescore_rst_conditioner.md
CORESCORE_RST_CONDITIONER -- requirements
Module: corescore_rst_conditioner

Sits upstream of the board clock generator. It turns a raw push-button into a clean, stretched, active-high reset for the clock generator's i_rst input.

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: number of consecutive cycles a synchronized button level must hold before it is accepted; legal range >= 1.
REQ-002 Parameter HOLD_CYCLES, default 16: minimum number of cycles o_rst stays high per assertion; legal range >= 1.
REQ-003 Parameter BUTTON_ACTIVE_LOW, default 1: 1 means i_btn low = pressed; 0 means i_btn high = pressed.
REQ-004 i_clk  input  1  sole clock; all state is clocked on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset of all state.
REQ-006 i_btn  input  1  raw, asynchronous, bouncing button level.
REQ-007 o_rst  output  1  registered, active-high conditioned reset, fed to the clock generator's i_rst.
REQ-008 o_press  output  1  registered, single-cycle pulse on each accepted press.
REQ-009 o_btn  output  1  registered debounced button level, 1 = pressed.

Function
REQ-010 Synchronizer: two-flop chain on i_btn, then polarity normalized to 1 = pressed.
REQ-011 Debounce: db_level (drives o_btn) and db_cnt, with width $clog2(DEBOUNCE_CYCLES+1).
  - Synced value equals db_level: db_cnt cleared.
  - Synced value differs: db_cnt increments.
  - db_cnt reaches DEBOUNCE_CYCLES-1 while still differing: db_level toggles on the next edge and db_cnt clears.
  - Net effect: db_level changes exactly DEBOUNCE_CYCLES edges after the synced value first differs.
REQ-012 A differing run shorter than DEBOUNCE_CYCLES cycles clears db_cnt and shall not change db_level.
REQ-013 o_press shall be 1 for exactly one cycle, on the edge after db_level goes 0->1, in every FSM state.
REQ-014 Latency: with raw i_btn stable from edge k, o_btn and o_press change at edge k+2+DEBOUNCE_CYCLES.
REQ-015 FSM states:
  - HOLD: o_rst=1, hold_cnt counting.
  - WAIT_REL: o_rst=1.
  - IDLE: o_rst=0.
  - hold_cnt width is $clog2(HOLD_CYCLES+1).
REQ-016 IDLE -> HOLD when db_level goes 0->1; o_rst rises on the same edge as o_press.
REQ-017 HOLD: hold_cnt increments once per cycle. After HOLD_CYCLES cycles in HOLD:
  - db_level=1: go to WAIT_REL.
  - db_level=0: go to IDLE, and o_rst is 0 on that edge.
REQ-018 WAIT_REL -> IDLE on the edge after db_level goes 1->0.
REQ-019 A press accepted in HOLD or WAIT_REL pulses o_press and does not restart hold_cnt.
REQ-020 A release during HOLD does not shorten the hold; o_rst is high for exactly HOLD_CYCLES cycles.
REQ-021 o_rst shall be glitch-free: a flop output, never combinational.

Reset
REQ-022 While i_rst_n=0, asynchronously:
  - o_rst=1, o_press=0, o_btn=0.
  - Sync flops hold the released level; db_cnt=0, hold_cnt=0.
  - State = HOLD.
REQ-023 After i_rst_n rises, o_rst stays high for exactly HOLD_CYCLES edges (power-on stretch), then follows REQ-017.
REQ-024 i_rst_n assertion in any state, mid-debounce or mid-hold, applies REQ-022 immediately, and all partial counts are discarded.
REQ-025 A button held through a reset release is re-debounced from the released level and produces one o_press after release.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, BUTTON_ACTIVE_LOW=1; edge 0 = first edge sampling the new i_btn level)
REQ-026 Reset stretch: i_rst_n=0 for 5 cycles with i_btn=1, then released -> o_rst=1 throughout reset and for the 16 edges after release, then 0; o_press=0 throughout.
REQ-027 Long press: from IDLE, i_btn=0 from edge 0, i_btn=1 from edge 40 -> o_press=1 only at edge 6; o_rst=1 from edge 6 through edge 45, 0 at edge 46.
REQ-028 Glitch reject: from IDLE, i_btn=0 for 3 cycles then 1 -> o_press, o_btn and o_rst stay 0.
REQ-029 Short press: from IDLE, i_btn=0 on edges 0-4, then 1 -> o_rst=1 on edges 6-21 (exactly 16 cycles), 0 at edge 22.
REQ-030 Reset mid-press: in WAIT_REL with i_btn=0, pulse i_rst_n low then high while the button stays held -> o_rst=1 continuously, one o_press at edge 6 after release, o_rst low only after a debounced release.
REQ-031 Bounce: from IDLE, i_btn toggles every cycle for 20 cycles, then settles at 0 -> exactly one o_press, 6 edges after it settles.
